// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issues MULT/DIV ops to the shared MDU, counts latency, stalls the pipe, pulses hilo_we.
// Optional MDU_PERF_CNT_EN adds perf_stall_cnt, a free-running count of stall_mdu cycles.
module mdu_issue_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mdu_reqE,
   input  logic [1:0] mdu_opE,
   input  logic       divisor_zeroE,
   input  logic       flushE,
   input  logic       stall_ext,
   output logic       unit_start,
   output logic [1:0] unit_op,
   output logic       unit_abort,
   output logic       hilo_we,
   output logic       stall_mdu,
   output logic       busy
`ifdef MDU_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic div;
   assign div  = mdu_opE[1];
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
   // IDLE outputs are gated by rst so nothing leaks out while reset is held
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      unit_start = 1'b0;
      unit_op    = 2'b00;
      unit_abort = 1'b0;
      hilo_we    = 1'b0;
      stall_mdu  = 1'b0;
      case (state)
         IDLE: if (rst && mdu_reqE && !flushE) begin
            stall_mdu = 1'b1;
            if (div && divisor_zeroE) state_nx = DONE;
            else begin
               unit_start = 1'b1;
               unit_op    = mdu_opE;
               state_nx   = BUSY;
               cnt_nx     = div ? DIV_LOAD : MUL_LOAD;
            end
         end
         BUSY: if (flushE) begin
            unit_abort = 1'b1;
            state_nx   = IDLE;
            cnt_nx     = '0;
         end else begin
            stall_mdu = 1'b1;
            if (cnt == '0) begin
               hilo_we  = 1'b1;
               state_nx = DONE;
            end else cnt_nx = cnt - 1'b1;
         end
         DONE: state_nx = stall_ext ? DONE : IDLE;
         default: state_nx = IDLE;
      endcase
   end
`ifdef MDU_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_stall_cnt <= '0;
      else if (stall_mdu) perf_stall_cnt <= perf_stall_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: scenario tasks plus a randomized run, checked against a timestamp-based model.
module tb_mdu_issue_ctrl;
   logic clk = 0, rst = 1, req = 0, dz = 0, fl = 0, se = 0;
   logic [1:0] op = 0;
   logic unit_start, unit_abort, hilo_we, stall_mdu, busy;
   logic [1:0] unit_op;
`ifdef MDU_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
`endif
   mdu_issue_ctrl dut (
      .clk(clk), .rst(rst), .mdu_reqE(req), .mdu_opE(op), .divisor_zeroE(dz),
      .flushE(fl), .stall_ext(se), .unit_start(unit_start), .unit_op(unit_op),
      .unit_abort(unit_abort), .hilo_we(hilo_we), .stall_mdu(stall_mdu), .busy(busy)
`ifdef MDU_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt)
`endif
   );
   always #5 clk = ~clk;
   int total = 0, bad = 0, cyc = 0, rel = 0;
   int mm, n_start, n_stall, n_hilo, n_abort, n_busy, hilo_rel, first_start, start2;
   int m_phase = 0, m_end = 0;
   logic [6:0] obs, exp_v, bad_obs, bad_exp;
   // model: phase 0 free, 1 op in flight finishing at absolute cycle m_end, 2 retiring
   function automatic logic [6:0] model_out();
      logic s = 0, a = 0, h = 0, st = 0, b = 0;
      logic [1:0] o = 0;
      if (m_phase == 0) begin
         if (rst && req && !fl) begin
            st = 1;
            if (!(op[1] && dz)) begin s = 1; o = op; end
         end
      end else if (m_phase == 1) begin
         b = 1;
         if (fl) a = 1;
         else begin st = 1; h = (cyc == m_end); end
      end else b = 1;
      return {s, o, a, h, st, b};
   endfunction
   task automatic clr();
      mm = 0; n_start = 0; n_stall = 0; n_hilo = 0; n_abort = 0; n_busy = 0;
      hilo_rel = -1; first_start = -1; start2 = -1; rel = 0;
   endtask
   task automatic tick();
      int np, ne;
      @(negedge clk); #1;
      exp_v = model_out();
      obs = {unit_start, unit_op, unit_abort, hilo_we, stall_mdu, busy};
      if (obs !== exp_v) begin
         if (mm == 0) begin bad_obs = obs; bad_exp = exp_v; end
         mm++;
      end
      if (obs[6]) begin n_start++; if (first_start < 0) first_start = rel; else start2 = rel; end
      if (obs[3]) n_abort++;
      if (obs[2]) begin n_hilo++; hilo_rel = rel; end
      if (obs[1]) n_stall++;
      if (obs[0]) n_busy++;
      np = m_phase; ne = m_end;
      if (!rst) np = 0;
      else if (m_phase == 0) begin
         if (req && !fl) begin
            np = (op[1] && dz) ? 2 : 1;
            ne = cyc + (op[1] ? 33 : 4);
         end
      end else if (m_phase == 1) begin
         if (fl) np = 0; else if (cyc == m_end) np = 2;
      end else if (!se) np = 0;
      @(posedge clk); #1;
      m_phase = np; m_end = ne; cyc++; rel++;
   endtask
   task automatic chk(string name, int got, int want);
      total++;
      if (got !== want) begin bad++; $display("FAIL %s got=%0d want=%0d", name, got, want); end
   endtask
   task automatic test_reset();
      clr();
      #1 rst = 0;
      tick();
      total++;
      if (obs !== 7'd0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 7'd0); end
      tick();
      rst = 1;
      tick();
      total++;
      if (mm !== 0) begin bad++; $display("FAIL reset_model got=%b want=%b", bad_obs, bad_exp); end
   endtask
   task automatic test_mult();
      clr(); op = 2'b00; dz = 0;
      for (int i = 0; i < 8; i++) begin req = (i <= 5); tick(); end
      chk("mult_model", mm, 0);
      chk("mult_start_at", first_start, 0);
      chk("mult_stall_cycles", n_stall, 5);
      chk("mult_hilo_at", hilo_rel, 4);
      chk("mult_hilo_count", n_hilo, 1);
      chk("mult_busy_cycles", n_busy, 5);
   endtask
   task automatic test_divu();
      clr(); op = 2'b11; dz = 0;
      for (int i = 0; i < 38; i++) begin req = (i <= 34); tick(); end
      chk("divu_model", mm, 0);
      chk("divu_stall_cycles", n_stall, 34);
      chk("divu_hilo_at", hilo_rel, 33);
      chk("divu_busy_cycles", n_busy, 34);
   endtask
   task automatic test_div_zero();
      clr(); op = 2'b10; dz = 1;
      for (int i = 0; i < 4; i++) begin req = (i <= 1); tick(); end
      dz = 0;
      chk("dz_model", mm, 0);
      chk("dz_start", n_start, 0);
      chk("dz_stall_cycles", n_stall, 1);
      chk("dz_hilo", n_hilo, 0);
      chk("dz_busy_cycles", n_busy, 1);
   endtask
   task automatic test_flush();
      clr(); op = 2'b10; dz = 0;
      for (int i = 0; i < 10; i++) begin req = (i <= 7); fl = (i == 7); tick(); end
      fl = 0;
      chk("flush7_model", mm, 0);
      chk("flush7_abort", n_abort, 1);
      chk("flush7_hilo", n_hilo, 0);
      chk("flush7_stall_cycles", n_stall, 7);
      clr();
      for (int i = 0; i < 36; i++) begin req = (i <= 33); fl = (i == 33); tick(); end
      fl = 0;
      chk("flush_last_model", mm, 0);
      chk("flush_last_hilo", n_hilo, 0);
      chk("flush_last_abort", n_abort, 1);
   endtask
   task automatic test_stall_ext();
      clr(); op = 2'b00; dz = 0; req = 1;
      for (int i = 0; i < 9; i++) begin se = (i >= 5 && i <= 7); tick(); end
      req = 0; se = 0;
      tick();
      chk("sext_model", mm, 0);
      chk("sext_starts", n_start, 1);
      chk("sext_busy_cycles", n_busy, 8);
   endtask
   task automatic test_back_to_back();
`ifdef MDU_PERF_CNT_EN
      logic [31:0] p0;
      p0 = perf_stall_cnt;
`endif
      clr(); op = 2'b00; dz = 0;
      for (int i = 0; i < 13; i++) begin req = (i <= 11); tick(); end
      chk("b2b_model", mm, 0);
      chk("b2b_first", first_start, 0);
      chk("b2b_second", start2, 6);
      chk("b2b_hilo_count", n_hilo, 2);
`ifdef MDU_PERF_CNT_EN
      chk("perf_two_mults", int'(perf_stall_cnt - p0), 10);
`endif
   endtask
   task automatic test_reset_mid();
      clr(); op = 2'b11; dz = 0; req = 1;
      repeat (5) tick();
      @(negedge clk); #1;
      rst = 0; req = 0;
      #1;
      obs = {unit_start, unit_op, unit_abort, hilo_we, stall_mdu, busy};
      total++;
      if (obs !== 7'd0) begin bad++; $display("FAIL reset_mid_outputs got=%b want=%b", obs, 7'd0); end
      m_phase = 0;
      tick();
      rst = 1;
      repeat (3) tick();
      chk("reset_mid_model", mm, 0);
      chk("reset_mid_hilo", n_hilo, 0);
      chk("reset_mid_abort", n_abort, 0);
   endtask
   task automatic test_random();
      clr();
      for (int i = 0; i < 600; i++) begin
         req = ($urandom_range(0, 3) != 0);
         op = 2'($urandom_range(0, 3));
         dz = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 24) == 0);
         se = ($urandom_range(0, 2) == 0);
         tick();
      end
      req = 0; fl = 0; se = 0; dz = 0;
      total++;
      if (mm !== 0) begin bad++; $display("FAIL random_model cycles=%0d got=%b want=%b", mm, bad_obs, bad_exp); end
      total++;
      if (n_hilo == 0) begin bad++; $display("FAIL random_hilo_seen got=0 want>0"); end
   endtask
   initial begin
      test_reset();
      test_mult();
      test_divu();
      test_div_zero();
      test_flush();
      test_stall_ext();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
